// File: rtl/ins_fetch.sv
// Instruction fetch: request FSM feeding a small in-order instruction queue.
// Optional fetch timeout with sticky error and HALT state: INS_FETCH_TIMEOUT_EN.
module ins_fetch #(
  parameter int QDEPTH    = 2,
  parameter int TO_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins_ad,
  output logic        PC_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  output logic        fetch_err
);

  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  if (!(QDEPTH == 2 || QDEPTH == 4) || TO_CYCLES < 2) begin : g_bad_param
    $error("ins_fetch: illegal QDEPTH or TO_CYCLES");
  end

`ifdef INS_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_e;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
`else
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;
`endif

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   ins_mem_q [QDEPTH];
  logic [31:0]   pc_mem_q  [QDEPTH];
  logic          push;
  logic          pop;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
`ifdef INS_FETCH_TIMEOUT_EN
    to_d    = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!flush && count_q < CW'(QDEPTH)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = ins_ad;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          push    = !flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: ;
    endcase
`ifdef INS_FETCH_TIMEOUT_EN
    // Timeout wins over a same-cycle flush; HALT is left only by reset.
    if ((state_q == REQ || state_q == DRAIN) && !imem_ack) begin
      if (to_q == TW'(TO_CYCLES - 1)) begin
        state_d = HALT;
        req_d   = 1'b0;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
`ifdef INS_FETCH_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
`ifdef INS_FETCH_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign pop = ins_valid & ins_ready;

  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (flush) begin
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pc_mem_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (push) begin
        ins_mem_q[wr_q] <= imem_rdata;
        pc_mem_q[wr_q]  <= addr_q;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins_valid = (count_q != '0);
  assign ins_out   = ins_mem_q[rd_q];
  assign ins_pc    = pc_mem_q[rd_q];
  assign PC_en     = rst_n &
                     (((state_q == REQ) & imem_ack & !flush) | flush);

`ifdef INS_FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
